// File: rtl/ofs_plat_avalon_mem_rr_arbiter_2to1.sv
// Two-source, one-sink Avalon-MM arbiter: round-robin at burst granularity,
// read data and write responses routed back through in-order tag FIFOs.
module ofs_plat_avalon_mem_rr_arbiter_2to1 #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned BURST_CNT_WIDTH = 7,
    parameter int unsigned RD_TAG_DEPTH    = 64,
    parameter int unsigned WR_TAG_DEPTH    = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic [ADDR_WIDTH-1:0]        s0_address,
    input  logic [BURST_CNT_WIDTH-1:0]   s0_burstcount,
    input  logic [DATA_WIDTH-1:0]        s0_writedata,
    input  logic [DATA_WIDTH/8-1:0]      s0_byteenable,
    input  logic                         s0_read,
    input  logic                         s0_write,
    output logic                         s0_waitrequest,
    output logic [DATA_WIDTH-1:0]        s0_readdata,
    output logic                         s0_readdatavalid,
    output logic [1:0]                   s0_response,
    output logic                         s0_writeresponsevalid,
    output logic [1:0]                   s0_writeresponse,

    input  logic [ADDR_WIDTH-1:0]        s1_address,
    input  logic [BURST_CNT_WIDTH-1:0]   s1_burstcount,
    input  logic [DATA_WIDTH-1:0]        s1_writedata,
    input  logic [DATA_WIDTH/8-1:0]      s1_byteenable,
    input  logic                         s1_read,
    input  logic                         s1_write,
    output logic                         s1_waitrequest,
    output logic [DATA_WIDTH-1:0]        s1_readdata,
    output logic                         s1_readdatavalid,
    output logic [1:0]                   s1_response,
    output logic                         s1_writeresponsevalid,
    output logic [1:0]                   s1_writeresponse,

    output logic [ADDR_WIDTH-1:0]        m_address,
    output logic [BURST_CNT_WIDTH-1:0]   m_burstcount,
    output logic [DATA_WIDTH-1:0]        m_writedata,
    output logic [DATA_WIDTH/8-1:0]      m_byteenable,
    output logic                         m_read,
    output logic                         m_write,
    input  logic                         m_waitrequest,
    input  logic [DATA_WIDTH-1:0]        m_readdata,
    input  logic                         m_readdatavalid,
    input  logic [1:0]                   m_response,
    input  logic                         m_writeresponsevalid,
    input  logic [1:0]                   m_writeresponse
);

    localparam int unsigned RD_AW = $clog2(RD_TAG_DEPTH);
    localparam int unsigned WR_AW = $clog2(WR_TAG_DEPTH);
    localparam int unsigned RD_PW = RD_AW + 1;
    localparam int unsigned WR_PW = WR_AW + 1;

    typedef struct packed {
        logic                       src;
        logic [BURST_CNT_WIDTH-1:0] bcnt;
    } rd_tag_t;

    logic                       last_grant_q, last_grant_d;
    logic                       wr_lock_q, wr_lock_d;
    logic                       lock_owner_q, lock_owner_d;
    logic [BURST_CNT_WIDTH-1:0] wr_beats_left_q, wr_beats_left_d;
    logic [BURST_CNT_WIDTH-1:0] rd_beat_cnt_q, rd_beat_cnt_d;
    logic [RD_PW-1:0]           rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
    logic [WR_PW-1:0]           wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
    rd_tag_t                    rd_mem_q [RD_TAG_DEPTH];
    logic                       wr_mem_q [WR_TAG_DEPTH];

    logic [1:0]                 s_read, s_write, req_ok;
    logic                       rd_full, rd_empty, wr_full, wr_empty, wr_ok;
    logic                       grant, do_read, do_write, accept;
    logic                       rd_push, wr_push, rd_pop_valid, rd_pop, wr_pop;
    logic [BURST_CNT_WIDTH-1:0] rd_cnt_inc;
    rd_tag_t                    rd_head;
    logic                       wr_head;

    assign s_read  = {s1_read, s0_read};
    assign s_write = {s1_write, s0_write};

    // Grant and command qualification: current requests plus registered state only.
    always_comb begin
        rd_full  = (rd_wptr_q - rd_rptr_q) == RD_PW'(RD_TAG_DEPTH);
        rd_empty = (rd_wptr_q == rd_rptr_q);
        wr_full  = (wr_wptr_q - wr_rptr_q) == WR_PW'(WR_TAG_DEPTH);
        wr_empty = (wr_wptr_q == wr_rptr_q);
        // Continuation beats of a locked burst never need a new write tag.
        wr_ok    = wr_lock_q || !wr_full;
        req_ok   = ((s_read & {2{!rd_full}}) | (s_write & {2{wr_ok}})) & {2{reset_n}};

        if (wr_lock_q)           grant = lock_owner_q;
        else if (req_ok == 2'b11) grant = !last_grant_q;
        else                     grant = req_ok[1];

        do_read  = s_read[grant] && !rd_full && !wr_lock_q && reset_n;
        do_write = s_write[grant] && wr_ok && reset_n;
        accept   = (do_read || do_write) && !m_waitrequest;
        rd_push  = do_read && !m_waitrequest;
        wr_push  = do_write && !m_waitrequest && !wr_lock_q;
    end

    assign m_read         = do_read;
    assign m_write        = do_write;
    assign m_address      = grant ? s1_address    : s0_address;
    assign m_burstcount   = grant ? s1_burstcount : s0_burstcount;
    assign m_writedata    = grant ? s1_writedata  : s0_writedata;
    assign m_byteenable   = grant ? s1_byteenable : s0_byteenable;
    assign s0_waitrequest = !(!grant && (do_read || do_write)) || m_waitrequest;
    assign s1_waitrequest = !( grant && (do_read || do_write)) || m_waitrequest;

    // Response steering from the FIFO heads.
    always_comb begin
        rd_head      = rd_mem_q[rd_rptr_q[RD_AW-1:0]];
        wr_head      = wr_mem_q[wr_rptr_q[WR_AW-1:0]];
        rd_pop_valid = m_readdatavalid && !rd_empty;
        rd_cnt_inc   = rd_beat_cnt_q + BURST_CNT_WIDTH'(1);
        rd_pop       = rd_pop_valid && (rd_cnt_inc == rd_head.bcnt);
        wr_pop       = m_writeresponsevalid && !wr_empty;
    end

    assign s0_readdata           = m_readdata;
    assign s1_readdata           = m_readdata;
    assign s0_response           = m_response;
    assign s1_response           = m_response;
    assign s0_readdatavalid      = rd_pop_valid && !rd_head.src;
    assign s1_readdatavalid      = rd_pop_valid &&  rd_head.src;
    assign s0_writeresponse      = m_writeresponse;
    assign s1_writeresponse      = m_writeresponse;
    assign s0_writeresponsevalid = wr_pop && !wr_head;
    assign s1_writeresponsevalid = wr_pop &&  wr_head;

    // Next-state for arbitration, burst lock and FIFO pointers.
    always_comb begin
        last_grant_d    = last_grant_q;
        wr_lock_d       = wr_lock_q;
        lock_owner_d    = lock_owner_q;
        wr_beats_left_d = wr_beats_left_q;
        rd_beat_cnt_d   = rd_beat_cnt_q;

        if (accept) last_grant_d = grant;

        if (do_write && !m_waitrequest) begin
            if (wr_lock_q) begin
                wr_beats_left_d = wr_beats_left_q - BURST_CNT_WIDTH'(1);
                if (wr_beats_left_q == BURST_CNT_WIDTH'(1)) wr_lock_d = 1'b0;
            end else if (m_burstcount > BURST_CNT_WIDTH'(1)) begin
                wr_lock_d       = 1'b1;
                lock_owner_d    = grant;
                wr_beats_left_d = m_burstcount - BURST_CNT_WIDTH'(1);
            end
        end

        if (rd_pop_valid) rd_beat_cnt_d = rd_pop ? '0 : rd_cnt_inc;

        rd_wptr_d = rd_wptr_q + RD_PW'(rd_push);
        rd_rptr_d = rd_rptr_q + RD_PW'(rd_pop);
        wr_wptr_d = wr_wptr_q + WR_PW'(wr_push);
        wr_rptr_d = wr_rptr_q + WR_PW'(wr_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q    <= 1'b1;
            wr_lock_q       <= 1'b0;
            lock_owner_q    <= 1'b0;
            wr_beats_left_q <= '0;
            rd_beat_cnt_q   <= '0;
            rd_wptr_q       <= '0;
            rd_rptr_q       <= '0;
            wr_wptr_q       <= '0;
            wr_rptr_q       <= '0;
        end else begin
            last_grant_q    <= last_grant_d;
            wr_lock_q       <= wr_lock_d;
            lock_owner_q    <= lock_owner_d;
            wr_beats_left_q <= wr_beats_left_d;
            rd_beat_cnt_q   <= rd_beat_cnt_d;
            rd_wptr_q       <= rd_wptr_d;
            rd_rptr_q       <= rd_rptr_d;
            wr_wptr_q       <= wr_wptr_d;
            wr_rptr_q       <= wr_rptr_d;
        end
    end

    // Tag storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (rd_push) rd_mem_q[rd_wptr_q[RD_AW-1:0]] <= '{src: grant, bcnt: m_burstcount};
        if (wr_push) wr_mem_q[wr_wptr_q[WR_AW-1:0]] <= grant;
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(m_readdatavalid && rd_empty))
        else $fatal(1, "readdatavalid with no outstanding read burst");
    assert property (@(posedge clk) disable iff (!reset_n) !(m_writeresponsevalid && wr_empty))
        else $fatal(1, "writeresponsevalid with no outstanding write burst");

endmodule
